// File: rtl/oled_frame_sequencer.sv
// SSD1306 OLED sequencer: panel reset pulse, init command stream, then one
// full-frame refresh per request, feeding bytes to the SPI shifter with D/C.
`timescale 1ns/1ps
module oled_frame_sequencer #(
    parameter int RES_LOW_CYCLES  = 270,
    parameter int RES_WAIT_CYCLES = 2700,
    parameter int FB_BYTES        = 1024
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        frame_req,
    output logic                        oled_res,
    output logic                        tx_valid,
    input  logic                        tx_ready,
    output logic [7:0]                  tx_data,
    output logic                        tx_dc,
    output logic                        fb_rd_en,
    output logic [$clog2(FB_BYTES)-1:0] fb_addr,
    input  logic [7:0]                  fb_data,
    output logic                        init_done,
    output logic                        busy,
    output logic                        frame_done,
    output logic [2:0]                  state_o
);

    localparam int WAIT_MAX = (RES_LOW_CYCLES > RES_WAIT_CYCLES) ? RES_LOW_CYCLES : RES_WAIT_CYCLES;
    localparam int WW       = $clog2(WAIT_MAX + 1);
    localparam int AW       = $clog2(FB_BYTES);

    localparam logic [WW-1:0] RES_LOW_LAST  = WW'(RES_LOW_CYCLES - 1);
    localparam logic [WW-1:0] RES_WAIT_LAST = WW'(RES_WAIT_CYCLES - 1);
    localparam logic [AW-1:0] FB_LAST       = AW'(FB_BYTES - 1);
    localparam logic [4:0]    INIT_LAST     = 5'd24;
    localparam logic [4:0]    ADDR_LAST     = 5'd5;

    typedef enum logic [2:0] {
        S_RES_LOW  = 3'd0,
        S_RES_WAIT = 3'd1,
        S_INIT     = 3'd2,
        S_IDLE     = 3'd3,
        S_ADDR     = 3'd4,
        S_PIXELS   = 3'd5
    } state_t;

    // Pixel sub-phase: read strobe, capture read data, hold byte until accepted
    typedef enum logic [1:0] {
        P_READ  = 2'd0,
        P_LATCH = 2'd1,
        P_SEND  = 2'd2
    } pix_t;

    function automatic logic [7:0] init_rom(input logic [4:0] idx);
        case (idx)
            5'd0:  init_rom = 8'hAE;
            5'd1:  init_rom = 8'hD5;
            5'd2:  init_rom = 8'h80;
            5'd3:  init_rom = 8'hA8;
            5'd4:  init_rom = 8'h3F;
            5'd5:  init_rom = 8'hD3;
            5'd6:  init_rom = 8'h00;
            5'd7:  init_rom = 8'h40;
            5'd8:  init_rom = 8'h8D;
            5'd9:  init_rom = 8'h14;
            5'd10: init_rom = 8'h20;
            5'd11: init_rom = 8'h00;
            5'd12: init_rom = 8'hA1;
            5'd13: init_rom = 8'hC8;
            5'd14: init_rom = 8'hDA;
            5'd15: init_rom = 8'h12;
            5'd16: init_rom = 8'h81;
            5'd17: init_rom = 8'hCF;
            5'd18: init_rom = 8'hD9;
            5'd19: init_rom = 8'hF1;
            5'd20: init_rom = 8'hDB;
            5'd21: init_rom = 8'h40;
            5'd22: init_rom = 8'hA4;
            5'd23: init_rom = 8'hA6;
            5'd24: init_rom = 8'hAF;
            default: init_rom = 8'h00;
        endcase
    endfunction

    // Column range 0..127, page range 0..7 before each frame
    function automatic logic [7:0] addr_cmd(input logic [2:0] idx);
        case (idx)
            3'd0: addr_cmd = 8'h21;
            3'd1: addr_cmd = 8'h00;
            3'd2: addr_cmd = 8'h7F;
            3'd3: addr_cmd = 8'h22;
            3'd4: addr_cmd = 8'h00;
            3'd5: addr_cmd = 8'h07;
            default: addr_cmd = 8'h00;
        endcase
    endfunction

    state_t          state_q, state_d;
    pix_t            pix_q, pix_d;
    logic [WW-1:0]   wait_q, wait_d;
    logic [4:0]      rom_idx_q, rom_idx_d;
    logic [4:0]      idx_nxt;
    logic [AW-1:0]   fb_addr_q, fb_addr_d;
    logic            oled_res_q, oled_res_d;
    logic            tx_valid_q, tx_valid_d;
    logic [7:0]      tx_data_q, tx_data_d;
    logic            tx_dc_q, tx_dc_d;
    logic            fb_rd_en_q, fb_rd_en_d;
    logic            init_done_q, init_done_d;
    logic            frame_done_q, frame_done_d;
    logic            pending_q, pending_d;
    logic            accept;

    assign accept = tx_valid_q & tx_ready;

    // State register and all registered outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_RES_LOW;
            pix_q        <= P_READ;
            wait_q       <= '0;
            rom_idx_q    <= '0;
            fb_addr_q    <= '0;
            oled_res_q   <= 1'b0;
            tx_valid_q   <= 1'b0;
            tx_data_q    <= 8'h00;
            tx_dc_q      <= 1'b0;
            fb_rd_en_q   <= 1'b0;
            init_done_q  <= 1'b0;
            frame_done_q <= 1'b0;
            pending_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            pix_q        <= pix_d;
            wait_q       <= wait_d;
            rom_idx_q    <= rom_idx_d;
            fb_addr_q    <= fb_addr_d;
            oled_res_q   <= oled_res_d;
            tx_valid_q   <= tx_valid_d;
            tx_data_q    <= tx_data_d;
            tx_dc_q      <= tx_dc_d;
            fb_rd_en_q   <= fb_rd_en_d;
            init_done_q  <= init_done_d;
            frame_done_q <= frame_done_d;
            pending_q    <= pending_d;
        end
    end

    // Next-state and output sequencing; a byte is held until tx_ready takes it
    always_comb begin
        state_d      = state_q;
        pix_d        = pix_q;
        wait_d       = wait_q;
        rom_idx_d    = rom_idx_q;
        fb_addr_d    = fb_addr_q;
        oled_res_d   = oled_res_q;
        tx_valid_d   = tx_valid_q;
        tx_data_d    = tx_data_q;
        tx_dc_d      = tx_dc_q;
        fb_rd_en_d   = 1'b0;
        init_done_d  = init_done_q;
        frame_done_d = 1'b0;
        pending_d    = pending_q;
        idx_nxt      = rom_idx_q + 5'd1;

        // Requests that arrive while busy are remembered (one deep)
        if (frame_req && (state_q != S_IDLE)) begin
            pending_d = 1'b1;
        end

        case (state_q)
            S_RES_LOW: begin
                if (wait_q == RES_LOW_LAST) begin
                    wait_d     = '0;
                    oled_res_d = 1'b1;
                    state_d    = S_RES_WAIT;
                end else begin
                    wait_d = wait_q + WW'(1);
                end
            end
            S_RES_WAIT: begin
                if (wait_q == RES_WAIT_LAST) begin
                    wait_d     = '0;
                    state_d    = S_INIT;
                    rom_idx_d  = '0;
                    tx_valid_d = 1'b1;
                    tx_data_d  = init_rom(5'd0);
                    tx_dc_d    = 1'b0;
                end else begin
                    wait_d = wait_q + WW'(1);
                end
            end
            S_INIT: begin
                if (accept) begin
                    if (rom_idx_q == INIT_LAST) begin
                        tx_valid_d  = 1'b0;
                        init_done_d = 1'b1;
                        state_d     = S_IDLE;
                    end else begin
                        rom_idx_d = idx_nxt;
                        tx_data_d = init_rom(idx_nxt);
                    end
                end
            end
            S_IDLE: begin
                if (frame_req || pending_q) begin
                    pending_d  = 1'b0;
                    state_d    = S_ADDR;
                    rom_idx_d  = '0;
                    tx_valid_d = 1'b1;
                    tx_data_d  = addr_cmd(3'd0);
                    tx_dc_d    = 1'b0;
                end
            end
            S_ADDR: begin
                if (accept) begin
                    if (rom_idx_q == ADDR_LAST) begin
                        tx_valid_d = 1'b0;
                        state_d    = S_PIXELS;
                        pix_d      = P_READ;
                        fb_rd_en_d = 1'b1;
                        fb_addr_d  = '0;
                    end else begin
                        rom_idx_d = idx_nxt;
                        tx_data_d = addr_cmd(idx_nxt[2:0]);
                    end
                end
            end
            S_PIXELS: begin
                case (pix_q)
                    P_READ: begin
                        pix_d = P_LATCH;
                    end
                    P_LATCH: begin
                        tx_data_d  = fb_data;
                        tx_dc_d    = 1'b1;
                        tx_valid_d = 1'b1;
                        pix_d      = P_SEND;
                    end
                    P_SEND: begin
                        if (accept) begin
                            tx_valid_d = 1'b0;
                            if (fb_addr_q == FB_LAST) begin
                                frame_done_d = 1'b1;
                                fb_addr_d    = '0;
                                pix_d        = P_READ;
                                state_d      = S_IDLE;
                            end else begin
                                fb_addr_d  = fb_addr_q + AW'(1);
                                fb_rd_en_d = 1'b1;
                                pix_d      = P_READ;
                            end
                        end
                    end
                    default: pix_d = P_READ;
                endcase
            end
            default: state_d = S_RES_LOW;
        endcase
    end

    assign oled_res   = oled_res_q;
    assign tx_valid   = tx_valid_q;
    assign tx_data    = tx_data_q;
    assign tx_dc      = tx_dc_q;
    assign fb_rd_en   = fb_rd_en_q;
    assign fb_addr    = fb_addr_q;
    assign init_done  = init_done_q;
    assign frame_done = frame_done_q;
    assign busy       = (state_q != S_IDLE);
    assign state_o    = state_q;

endmodule

// File: tb/tb_oled_frame_sequencer.sv
// Bench for oled_frame_sequencer: byte scoreboard on the tx handshake,
// framebuffer read model, and scenario tasks run in sequence.
`timescale 1ns/1ps
module tb_oled_frame_sequencer;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       frame_req = 1'b0;
    logic       tx_ready = 1'b0;
    logic [7:0] fb_data = 8'h00;
    logic       oled_res, tx_valid, tx_dc, fb_rd_en, init_done, busy, frame_done;
    logic [7:0] tx_data;
    logic [9:0] fb_addr;
    logic [2:0] state_o;

    oled_frame_sequencer dut (
        .clk(clk), .reset_n(reset_n), .frame_req(frame_req), .oled_res(oled_res),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data), .tx_dc(tx_dc),
        .fb_rd_en(fb_rd_en), .fb_addr(fb_addr), .fb_data(fb_data),
        .init_done(init_done), .busy(busy), .frame_done(frame_done), .state_o(state_o)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int viol = 0;
    int pix_cnt = 0;
    int fd_cnt = 0;
    int ready_mode = 0;   // 0: always ready, 1: ~30% random stalls
    bit stall = 1'b0;

    logic [8:0] sb[$];
    logic [8:0] exp_b;
    logic [7:0] mem [0:1023];
    logic [7:0] init_tab [0:24] = '{8'hAE, 8'hD5, 8'h80, 8'hA8, 8'h3F, 8'hD3, 8'h00, 8'h40, 8'h8D,
                                   8'h14, 8'h20, 8'h00, 8'hA1, 8'hC8, 8'hDA, 8'h12, 8'h81, 8'hCF,
                                   8'hD9, 8'hF1, 8'hDB, 8'h40, 8'hA4, 8'hA6, 8'hAF};
    logic [7:0] addr_tab [0:5] = '{8'h21, 8'h00, 8'h7F, 8'h22, 8'h00, 8'h07};

    // tx_ready driver
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (stall) tx_ready = 1'b0;
            else if (ready_mode == 0) tx_ready = 1'b1;
            else tx_ready = ($urandom_range(0, 99) >= 30);
        end
    end

    // Framebuffer model: data appears only in the cycle after the read strobe
    initial begin
        logic       rd_pend;
        logic [9:0] rd_addr;
        forever begin
            @(negedge clk);
            rd_pend = fb_rd_en;
            rd_addr = fb_addr;
            @(posedge clk);
            #1;
            fb_data = rd_pend ? mem[rd_addr] : 8'hEE;
        end
    end

    // Scoreboard and handshake protocol monitor
    logic       pv = 1'b0, pacc = 1'b0, pdc = 1'b0, pfd = 1'b0;
    logic [7:0] pd = 8'h00;
    always @(negedge clk) begin
        if (!reset_n) begin
            pv  = 1'b0;
            pfd = 1'b0;
        end else begin
            if (fb_rd_en && tx_valid) viol++;
            if (pv && !pacc && (!tx_valid || tx_data !== pd || tx_dc !== pdc)) viol++;
            if (frame_done && pfd) viol++;
            if (frame_done) fd_cnt++;
            if (tx_valid && tx_ready) begin
                total++;
                if (sb.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_byte got dc=%0b data=%02h exp=none", tx_dc, tx_data);
                end else begin
                    exp_b = sb.pop_front();
                    if ({tx_dc, tx_data} !== exp_b) begin
                        bad++;
                        $display("FAIL tx_byte got dc=%0b data=%02h exp dc=%0b data=%02h",
                                 tx_dc, tx_data, exp_b[8], exp_b[7:0]);
                    end
                end
                if (tx_dc) pix_cnt++;
            end
            pv   = tx_valid;
            pacc = tx_valid && tx_ready;
            pd   = tx_data;
            pdc  = tx_dc;
            pfd  = frame_done;
        end
    end

    task automatic push_init();
        for (int i = 0; i < 25; i++) sb.push_back({1'b0, init_tab[i]});
    endtask

    task automatic push_frame();
        for (int i = 0; i < 6; i++) sb.push_back({1'b0, addr_tab[i]});
        for (int i = 0; i < 1024; i++) sb.push_back({1'b1, mem[i]});
    endtask

    task automatic pulse_req();
        @(negedge clk);
        frame_req = 1'b1;
        @(negedge clk);
        frame_req = 1'b0;
    endtask

    task automatic wait_frames(input int target, input int limit);
        int n = 0;
        while (fd_cnt < target && n < limit) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        total++;
        if (state_o !== 3'd0) begin
            bad++; $display("FAIL reset_state got=%0d exp=0", state_o);
        end
        total++;
        if (busy !== 1'b1) begin
            bad++; $display("FAIL reset_busy got=%0b exp=1", busy);
        end
        total++;
        if ({oled_res, tx_valid, tx_data, tx_dc, fb_rd_en, fb_addr, init_done, frame_done} !== 24'h0) begin
            bad++;
            $display("FAIL reset_outputs got res=%0b v=%0b d=%02h dc=%0b rd=%0b a=%0d id=%0b fd=%0b exp=all0",
                     oled_res, tx_valid, tx_data, tx_dc, fb_rd_en, fb_addr, init_done, frame_done);
        end
    endtask

    task automatic test_init();
        int n = 0;
        int m = 0;
        int k = 0;
        ready_mode = 0;
        push_init();
        @(negedge clk);
        reset_n = 1'b1;
        while (n < 1000) begin
            @(posedge clk); #1;
            n++;
            if (oled_res) break;
        end
        total++;
        if (n !== 270) begin
            bad++; $display("FAIL res_low_len got=%0d exp=270", n);
        end
        while (m < 4000) begin
            @(posedge clk); #1;
            m++;
            if (tx_valid) break;
        end
        total++;
        if (m < 2700 || m > 2702) begin
            bad++; $display("FAIL res_wait_len got=%0d exp=2700..2702", m);
        end
        total++;
        if ({tx_dc, tx_data} !== 9'h0AE) begin
            bad++; $display("FAIL first_cmd got dc=%0b data=%02h exp dc=0 data=ae", tx_dc, tx_data);
        end
        while (k < 200) begin
            @(negedge clk);
            k++;
            if (tx_valid && tx_ready && tx_data == 8'hAF) break;
        end
        total++;
        if (init_done !== 1'b0 || k >= 200) begin
            bad++; $display("FAIL init_done_early got=%0b exp=0 (wait=%0d)", init_done, k);
        end
        @(posedge clk); #1;
        total++;
        if (init_done !== 1'b1) begin
            bad++; $display("FAIL init_done_after_af got=%0b exp=1", init_done);
        end
        @(negedge clk);
        total++;
        if (sb.size() !== 0 || state_o !== 3'd3 || busy !== 1'b0) begin
            bad++; $display("FAIL init_end got left=%0d state=%0d busy=%0b exp left=0 state=3 busy=0",
                            sb.size(), state_o, busy);
        end
    endtask

    task automatic test_frame();
        int base = fd_cnt;
        for (int i = 0; i < 1024; i++) mem[i] = 8'(i) ^ 8'h5A;
        pix_cnt = 0;
        push_frame();
        pulse_req();
        wait_frames(base + 1, 5000);
        repeat (5) @(negedge clk);
        total++;
        if (fd_cnt !== base + 1) begin
            bad++; $display("FAIL frame_done_count got=%0d exp=%0d", fd_cnt, base + 1);
        end
        total++;
        if (sb.size() !== 0 || pix_cnt !== 1024) begin
            bad++; $display("FAIL frame_bytes got left=%0d pix=%0d exp left=0 pix=1024", sb.size(), pix_cnt);
        end
        total++;
        if (state_o !== 3'd3 || busy !== 1'b0 || fb_addr !== 10'd0) begin
            bad++; $display("FAIL frame_idle got state=%0d busy=%0b addr=%0d exp 3/0/0", state_o, busy, fb_addr);
        end
    endtask

    task automatic test_stall();
        int base = fd_cnt;
        int sv = 0;
        int n = 0;
        pix_cnt = 0;
        push_frame();
        pulse_req();
        while (pix_cnt < 500 && n < 3000) begin
            @(posedge clk); #3;
            n++;
        end
        stall = 1'b1;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 47; i++) begin
            @(negedge clk);
            if (!tx_valid || tx_data !== mem[500] || tx_dc !== 1'b1 || fb_rd_en || fb_addr !== 10'd500) sv++;
        end
        total++;
        if (sv !== 0 || pix_cnt !== 500) begin
            bad++; $display("FAIL stall_hold got bad_cycles=%0d pix=%0d exp 0/500", sv, pix_cnt);
        end
        stall = 1'b0;
        wait_frames(base + 1, 5000);
        repeat (5) @(negedge clk);
        total++;
        if (fd_cnt !== base + 1 || sb.size() !== 0 || pix_cnt !== 1024) begin
            bad++; $display("FAIL stall_frame got frames=%0d left=%0d pix=%0d exp %0d/0/1024",
                            fd_cnt, sb.size(), pix_cnt, base + 1);
        end
    endtask

    task automatic test_pending();
        int base = fd_cnt;
        push_frame();
        push_frame();
        pulse_req();
        repeat (100) @(negedge clk);
        pulse_req();
        repeat (200) @(negedge clk);
        pulse_req();
        wait_frames(base + 2, 8000);
        repeat (1200) @(negedge clk);
        total++;
        if (fd_cnt !== base + 2 || sb.size() !== 0) begin
            bad++; $display("FAIL pending_frames got frames=%0d left=%0d exp %0d/0", fd_cnt, sb.size(), base + 2);
        end
    endtask

    task automatic test_back_to_back();
        int base = fd_cnt;
        int n = 0;
        push_frame();
        push_frame();
        pulse_req();
        while (n < 5000) begin
            @(negedge clk);
            n++;
            if (tx_valid && tx_ready && tx_dc && fb_addr == 10'd1023) break;
        end
        frame_req = 1'b1;
        @(negedge clk);
        frame_req = 1'b0;
        total++;
        if (state_o !== 3'd3 || frame_done !== 1'b1) begin
            bad++; $display("FAIL b2b_idle got state=%0d fd=%0b exp 3/1", state_o, frame_done);
        end
        @(negedge clk);
        total++;
        if (state_o !== 3'd4 || tx_valid !== 1'b1 || tx_data !== 8'h21) begin
            bad++; $display("FAIL b2b_restart got state=%0d v=%0b d=%02h exp 4/1/21", state_o, tx_valid, tx_data);
        end
        wait_frames(base + 2, 5000);
        repeat (1200) @(negedge clk);
        total++;
        if (fd_cnt !== base + 2 || sb.size() !== 0) begin
            bad++; $display("FAIL b2b_frames got frames=%0d left=%0d exp %0d/0", fd_cnt, sb.size(), base + 2);
        end
    endtask

    task automatic test_reset_mid();
        int base;
        int n = 0;
        pix_cnt = 0;
        push_frame();
        pulse_req();
        while (pix_cnt < 300 && n < 3000) begin
            @(posedge clk); #3;
            n++;
        end
        reset_n = 1'b0;
        #1;
        total++;
        if (tx_valid !== 1'b0 || oled_res !== 1'b0 || busy !== 1'b1 || state_o !== 3'd0 || init_done !== 1'b0) begin
            bad++; $display("FAIL mid_reset got v=%0b res=%0b busy=%0b state=%0d id=%0b exp 0/0/1/0/0",
                            tx_valid, oled_res, busy, state_o, init_done);
        end
        sb.delete();
        repeat (4) @(negedge clk);
        base = fd_cnt;
        ready_mode = 1;
        for (int i = 0; i < 1024; i++) mem[i] = 8'(i * 37 + 11);
        push_init();
        push_frame();
        reset_n = 1'b1;
        n = 0;
        while (state_o != 3'd2 && n < 4000) begin
            @(negedge clk);
            n++;
        end
        frame_req = 1'b1;
        @(negedge clk);
        frame_req = 1'b0;
        n = 0;
        while (!init_done && n < 1000) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (init_done !== 1'b1) begin
            bad++; $display("FAIL replay_init got init_done=%0b exp=1", init_done);
        end
        wait_frames(base + 1, 8000);
        repeat (1500) @(negedge clk);
        total++;
        if (fd_cnt !== base + 1 || sb.size() !== 0) begin
            bad++; $display("FAIL init_pending_frames got frames=%0d left=%0d exp %0d/0", fd_cnt, sb.size(), base + 1);
        end
    endtask

    task automatic test_protocol();
        total++;
        if (viol !== 0) begin
            bad++; $display("FAIL handshake_protocol got violations=%0d exp=0", viol);
        end
    endtask

    initial begin
        test_reset();
        test_init();
        test_frame();
        test_stall();
        test_pending();
        test_back_to_back();
        test_reset_mid();
        test_protocol();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
